// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM state type and result-flag bundle shared by alu_pipe.
package alu_pkg;

  localparam int unsigned ALUC_W = 4;

  localparam logic [ALUC_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUC_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUC_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUC_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [ALUC_W-1:0] ALU_SLTU = 4'd6;
  localparam logic [ALUC_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [ALUC_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [ALUC_W-1:0] ALU_SRA  = 4'd9;
  localparam logic [ALUC_W-1:0] ALU_MUL  = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial product per cycle.
// The start cycle performs the first step, so done is registered and rises
// WIDTH-1 edges after start; p holds the low WIDTH bits of a*b while done=1.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  // One shift-add step per cycle; start applies step 1 to the raw operands.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = b[0] ? a : '0;
      mcand_d  = a << 1;
      mplier_d = b >> 1;
      cnt_d    = CNT_W'(1);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Multiplier state registers; reset discards any partial product.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered EX-stage ALU with valid/ready on both sides.
// Optional macro ALU_MUL_EN enables opcode 10 (iterative MUL) and the BUSY state;
// without it opcode 10 is illegal and the block has no multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic [ALUC_W-1:0] aluc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  r,
  output logic              z,
  output logic              c,
  output logic              v,
  output logic              err
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] res_c;
  alu_flags_t       flags_c;

  logic             in_fire;
  logic             out_fire;
  logic             load_alu;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] r_q, r_d;
  alu_flags_t       flags_q, flags_d;

  // Single-cycle datapath; unknown opcodes yield r=0 with err set.
  always_comb begin
    add_ext = {1'b0, x} + {1'b0, y};
    sub_ext = {1'b0, x} + {1'b0, ~y} + (WIDTH + 1)'(1);
    shamt   = y[SH_W-1:0];
    res_c   = '0;
    flags_c = '{z: 1'b0, c: 1'b0, v: 1'b0, err: 1'b0};
    case (aluc)
      ALU_ADD: begin
        res_c     = add_ext[WIDTH-1:0];
        flags_c.c = add_ext[WIDTH];
        flags_c.v = (x[WIDTH-1] == y[WIDTH-1]) && (add_ext[WIDTH-1] != x[WIDTH-1]);
      end
      ALU_SUB: begin
        res_c     = sub_ext[WIDTH-1:0];
        flags_c.c = sub_ext[WIDTH];
        flags_c.v = (x[WIDTH-1] != y[WIDTH-1]) && (sub_ext[WIDTH-1] != x[WIDTH-1]);
      end
      ALU_AND:  res_c = x & y;
      ALU_OR:   res_c = x | y;
      ALU_XOR:  res_c = x ^ y;
      ALU_SLT:  res_c = WIDTH'($signed(x) < $signed(y));
      ALU_SLTU: res_c = WIDTH'(x < y);
      ALU_SLL:  res_c = x << shamt;
      ALU_SRL:  res_c = x >> shamt;
      ALU_SRA:  res_c = $unsigned($signed(x) >>> shamt);
      default:  flags_c.err = 1'b1;
    endcase
    flags_c.z = (res_c == '0);
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

`ifdef ALU_MUL_EN
  alu_state_e       state_q, state_d;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;

  assign is_mul    = (aluc == ALU_MUL);
  assign mul_start = in_fire && is_mul;
  assign load_alu  = in_fire && !is_mul;
  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .clrn  (clrn),
    .start (mul_start),
    .a     (x),
    .b     (y),
    .done  (mul_done),
    .p     (mul_p)
  );

  // A MUL parks the FSM in BUSY until the multiplier reports done.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (mul_start) begin
        state_d = BUSY;
      end
    end else if (mul_done) begin
      state_d = IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign load_alu = in_fire;
  assign in_ready = !out_valid_q || out_ready;
`endif

  // Result register: consume on out_fire, replace on a new single-cycle op or MUL completion.
  always_comb begin
    out_valid_d = out_valid_q;
    r_d         = r_q;
    flags_d     = flags_q;
    if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (load_alu) begin
      out_valid_d = 1'b1;
      r_d         = res_c;
      flags_d     = flags_c;
    end
`ifdef ALU_MUL_EN
    if (mul_done) begin
      out_valid_d = 1'b1;
      r_d         = mul_p;
      flags_d     = '{z: (mul_p == '0), c: 1'b0, v: 1'b0, err: 1'b0};
    end
`endif
  end

  // Output registers; reset presents a zero result with z set.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      flags_q     <= '{z: 1'b1, c: 1'b0, v: 1'b0, err: 1'b0};
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign z         = flags_q.z;
  assign c         = flags_q.c;
  assign v         = flags_q.v;
  assign err       = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed + random scoreboard bench for alu_pipe (WIDTH=32).
// Honours ALU_MUL_EN the same way the design does.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         clrn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [3:0]   aluc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         z;
  logic         c;
  logic         v;
  logic         err;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0]   op_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .aluc      (aluc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .z         (z),
    .c         (c),
    .v         (v),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rr, input logic cc, input logic vv, input logic ee);
    return {rr, (rr == 32'd0), cc, vv, ee};
  endfunction

  // Reference model built on 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic        cf, vf, ef;
    longint      sxa, sxb, sres;
    logic [63:0] wide;
    res = 32'd0; cf = 1'b0; vf = 1'b0; ef = 1'b0;
    sxa = longint'({{32{a[31]}}, a});
    sxb = longint'({{32{b[31]}}, b});
    case (op)
      4'd0: begin
        wide = 64'(a) + 64'(b); res = wide[31:0]; cf = wide[32];
        sres = sxa + sxb; vf = (sres != longint'({{32{res[31]}}, res}));
      end
      4'd1: begin
        wide = 64'(a) - 64'(b); res = wide[31:0]; cf = (a >= b);
        sres = sxa - sxb; vf = (sres != longint'({{32{res[31]}}, res}));
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = (sxa < sxb) ? 32'd1 : 32'd0;
      4'd6: res = (a < b) ? 32'd1 : 32'd0;
      4'd7: res = a << b[4:0];
      4'd8: res = a >> b[4:0];
      4'd9: begin sres = sxa >>> b[4:0]; res = sres[31:0]; end
`ifdef ALU_MUL_EN
      4'd10: begin wide = 64'(a) * 64'(b); res = wide[31:0]; end
`endif
      default: ef = 1'b1;
    endcase
    return {res, (res == 32'd0), cf, vf, ef};
  endfunction

  function automatic bit mul_op(input logic [3:0] op);
`ifdef ALU_MUL_EN
    return (op == 4'd10);
`else
    return (op == 4'd15) && (op == 4'd10);
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Wait (bounded) for in_ready, then let the accepting edge pass.
  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout: observed in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e, input bit chk_lat);
    x = a; y = b; aluc = op; in_valid = 1'b1;
    sb.push_back(e);
    wait_accept();
    in_valid = 1'b0;
    if (chk_lat) chk("latency_out_valid", 64'(out_valid), 64'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each output handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_result: observed r=%0h expected none", r);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 64'({r, z, c, v, err}), 64'(mon_e));
      end
    end
  end

  initial begin
    clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; aluc = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outputs", 64'({r, z, c, v, err}), 64'({32'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
    clrn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;

    // Directed vectors
    issue(ALU_ADD,  32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0), 1'b1);
    issue(ALU_ADD,  32'hFFFF_FFFF, 32'h1, mk(32'h0, 1'b1, 1'b0, 1'b0), 1'b1);
    issue(ALU_SUB,  32'd5, 32'd5, mk(32'h0, 1'b1, 1'b0, 1'b0), 1'b1);
    issue(ALU_SUB,  32'd0, 32'd1, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(ALU_SUB,  32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), 1'b1);
    issue(ALU_SLT,  32'hFFFF_FFFF, 32'd1, mk(32'd1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(ALU_SRA,  32'h8000_0000, 32'h24, mk(32'hF800_0000, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(ALU_SRL,  32'h8000_0000, 32'h24, mk(32'h0800_0000, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(ALU_SLL,  32'h0000_0003, 32'h1F, mk(32'h8000_0000, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(ALU_XOR,  32'hA5A5_A5A5, 32'hA5A5_A5A5, mk(32'h0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(4'd15,    32'h1234, 32'h5678, mk(32'h0, 1'b0, 1'b0, 1'b1), 1'b1);
`ifndef ALU_MUL_EN
    issue(4'd10,    32'd7, 32'd9, mk(32'h0, 1'b0, 1'b0, 1'b1), 1'b1);
`endif
    drain();

    // Backpressure: first result held while two more ADDs wait
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd1, 32'd2, mk(32'd3, 1'b0, 1'b0, 1'b0), 1'b1);
    x = 32'd10; y = 32'd20; aluc = ALU_ADD; in_valid = 1'b1;
    sb.push_back(mk(32'd30, 1'b0, 1'b0, 1'b0));
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_hold", 64'({out_valid, r, z, c, v, err}), 64'({1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    x = 32'd100; y = 32'd200;
    sb.push_back(mk(32'd300, 1'b0, 1'b0, 1'b0));
    wait_accept();
    in_valid = 1'b0;
    chk("bp_third_valid", 64'(out_valid), 64'(1));
    drain();

`ifdef ALU_MUL_EN
    // MUL latency and busy window
    issue(ALU_MUL, 32'd12345, 32'd678, mk(32'd8369910, 1'b0, 1'b0, 1'b0), 1'b0);
    chk("mul_ready_low", 64'(in_ready), 64'(0));
    for (int k = 1; k < 32; k++) begin
      @(posedge clk);
      #1;
      chk("mul_busy", 64'({in_ready, out_valid}), 64'(0));
    end
    @(posedge clk);
    #1;
    chk("mul_latency", 64'(out_valid), 64'(1));
    drain();

    // Reset in the middle of a MUL leaves no result behind
    x = 32'd77; y = 32'd99; aluc = ALU_MUL; in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clrn = 1'b0;
    #2;
    chk("abort_rst_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    clrn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("abort_no_result", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'(1));
`endif

    // Random mix with occasional consumer stalls
    for (int i = 0; i < 60; i++) begin
      op_r = 4'($urandom_range(0, 15));
      a_r  = pick();
      b_r  = pick();
      issue(op_r, a_r, b_r, model(op_r, a_r, b_r), !mul_op(op_r));
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
